mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single 32-bit memory bus (cache/PSRAM controller slave port) among up to four bus masters: CPU, serialboot, and future DMA engines. It implements the m_req/m_gnt ownership protocol that serialboot already uses. Grants are round-robin and held until the owner drops its request. The owner's address, data and strobes are muxed onto the slave port, and slave ready/read data are routed back to the owner. Handoff never happens while a slave access is in flight.

## Interface
- NM, 2, number of masters (2..4); master 0 is the CPU.
- AW, 32, address width.
- DW, 32, data width.

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- m_req  in  NM  per-master bus request
- m_gnt  out  NM  one-hot grant, registered
- m_a  in  NM*AW  master addresses, master i at [i*AW +: AW]
- m_d  in  NM*DW  master write data, same packing
- m_we  in  NM  master write strobes
- m_rd  in  NM  master read strobes
- m_spo  out  DW  read data, broadcast to all masters
- m_ready  out  NM  per-master ready
- s_a  out  AW  slave address
- s_d  out  DW  slave write data
- s_we  out  1  slave write strobe
- s_rd  out  1  slave read strobe
- s_spo  in  DW  slave read data
- s_ready  in  1  slave idle / access complete

## Operation
- State: registered owner index `own`, registered `busy` flag (IDLE/OWNED), registered round-robin pointer `last`.
- IDLE: if any m_req is high, rr_pick selects the first requester at or after (last+1) mod NM. Next cycle: `busy`=1, `own`=winner, m_gnt[winner]=1, `last`=winner.
- OWNED: the owner's m_a/m_d/m_we/m_rd drive s_a/s_d/s_we/s_rd. m_ready[own]=s_ready. All other m_ready are 0. Strobes from non-owners are dropped and never reach the slave.
- Release condition: m_req[own]=0, s_ready=1, and m_we[own]=0, m_rd[own]=0, all in the same cycle.
- On release with other requesters pending: grant passes directly to the rr_pick winner next cycle. There is no IDLE bubble, and m_gnt changes one-hot to one-hot.
- On release with no requesters: go to IDLE with m_gnt=0.
- While the owner holds m_req high, the grant is never revoked. There is no preemption.
- IDLE outputs: s_we=0, s_rd=0, s_a=0, s_d=0, m_ready=0.
- m_spo = s_spo at all times; masters qualify it with their own m_ready.

## Timing
- Reset values:
  - m_gnt=0, busy=0, own=0.
  - last=NM-1, so master 0 wins the first tie.
  - s_we=0, s_rd=0, m_ready=0, s_a=0, s_d=0.
- Request to grant: 1 cycle. m_req rises in cycle t, m_gnt is high in t+1, and the first forwarded strobe can occur in t+1.
- s_* paths are combinational muxes driven by the registered `own`/`busy`. There is zero added latency on strobes, ready and read data.
- Owner drops m_req in the same cycle as a strobe: the strobe is forwarded and release waits until s_ready=1 with no strobe.
- Owner drops m_req while s_ready=0: m_gnt stays held until s_ready returns to 1.
- Several requests arrive in the cycle of release: exactly one winner, chosen strictly in round-robin order.
- A master that drops m_req before it is granted: nothing is recorded.
- rst mid-access:
  - The next cycle shows m_gnt=0 and no strobes.
  - The slave's own reset is responsible for aborting its access.
- A strobe may be forwarded only while the one-hot m_gnt matches `own`. Assert this in simulation.

## Structure
- Shared package `bus_pkg`: AW/DW defaults, NM_MAX=4, a master-index typedef (2 bits), and named constants MST_CPU=0, MST_SERIALBOOT=1.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are a request vector and the last-owner index; outputs are a valid flag and the winner index. It is unit-tested separately.
- Top level holds the owner/busy/last registers and the muxes. Expected size is about 150–250 lines of RTL in total.

## Test plan
- Reset, then master 0 req=1 at cycle 5 → m_gnt=01 at cycle 6; write A=0x100, D=0xDEADBEEF is seen on s_a/s_d/s_we in the same cycle.
- Both masters request at once from IDLE after reset → master 0 is granted. Master 0 releases → master 1 is granted in the very next cycle with no IDLE cycle. Master 1 releases while master 0 requests → master 0 is granted.
- Master 1 (serialboot-style) issues a write while the slave holds s_ready=0 for 10 cycles and drops m_req in between → m_gnt stays 10 until s_ready=1, then moves to master 0.
- Non-owner pulses m_we=1 with A=0x200 → s_we stays 0 and the slave model sees no write to 0x200.
- Read by owner with s_spo=0x12345678 and s_ready=1 → m_ready[own]=1, m_ready of the other master=0, and m_spo=0x12345678.
- rst asserted while the slave is busy with master 1 owning the bus → next cycle m_gnt=0 and s_we=s_rd=0. The first request after reset is granted with master 0 priority.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared memory-bus definitions: default widths, master limits and master ids.
package bus_pkg;

    localparam int unsigned AW_DEF = 32;
    localparam int unsigned DW_DEF = 32;
    localparam int unsigned NM_MAX = 4;

    // Master index wide enough for NM_MAX masters
    typedef logic [1:0] mst_idx_t;

    localparam mst_idx_t MST_CPU        = 2'd0;
    localparam mst_idx_t MST_SERIALBOOT = 2'd1;

    // Arbiter ownership state
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after (last+1) mod NM.
module rr_pick
    import bus_pkg::*;
#(
    parameter int unsigned NM = 2
) (
    input  logic [NM-1:0] req,
    input  mst_idx_t      last,
    output logic          valid,
    output mst_idx_t      winner
);

    // Scan masters starting just after the previous owner, wrapping once
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int unsigned k = 1; k <= NM; k++) begin
            int unsigned idx;
            idx = 32'(last) + k;
            if (idx >= NM) idx = idx - NM;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = mst_idx_t'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory slave port among NM bus masters.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NM = 2,
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM-1:0]    m_req,
    output logic [NM-1:0]    m_gnt,
    input  logic [NM*AW-1:0] m_a,
    input  logic [NM*DW-1:0] m_d,
    input  logic [NM-1:0]    m_we,
    input  logic [NM-1:0]    m_rd,
    output logic [DW-1:0]    m_spo,
    output logic [NM-1:0]    m_ready,
    output logic [AW-1:0]    s_a,
    output logic [DW-1:0]    s_d,
    output logic             s_we,
    output logic             s_rd,
    input  logic [DW-1:0]    s_spo,
    input  logic             s_ready
);

    arb_state_t state;
    mst_idx_t   own;
    mst_idx_t   last;
    logic       pick_valid;
    mst_idx_t   pick_win;
    logic       release_ok;

    rr_pick #(.NM(NM)) u_pick (
        .req    (m_req),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_win)
    );

    // Owner may let go only when idle on the slave and no strobe is pending
    assign release_ok = !m_req[own] && s_ready && !m_we[own] && !m_rd[own];

    // Ownership FSM: grant, hold, and direct handoff without an idle bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            own   <= MST_CPU;
            last  <= mst_idx_t'(NM - 1);
            m_gnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state <= ARB_OWNED;
                        own   <= pick_win;
                        last  <= pick_win;
                        m_gnt <= NM'(1) << pick_win;
                    end
                end
                ARB_OWNED: begin
                    if (release_ok) begin
                        if (pick_valid) begin
                            own   <= pick_win;
                            last  <= pick_win;
                            m_gnt <= NM'(1) << pick_win;
                        end else begin
                            state <= ARB_IDLE;
                            m_gnt <= '0;
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    m_gnt <= '0;
                end
            endcase
        end
    end

    // Slave-side mux from the registered owner; zero added latency
    always_comb begin
        s_a     = '0;
        s_d     = '0;
        s_we    = 1'b0;
        s_rd    = 1'b0;
        m_ready = '0;
        if (state == ARB_OWNED) begin
            s_a          = m_a[32'(own)*AW +: AW];
            s_d          = m_d[32'(own)*DW +: DW];
            s_we         = m_we[own];
            s_rd         = m_rd[own];
            m_ready[own] = s_ready;
        end
    end

    // Read data is broadcast; masters qualify it with their own ready
    assign m_spo = s_spo;

    // A forwarded strobe must belong to the master holding the grant
    a_strobe_owner: assert property (@(posedge clk) disable iff (rst)
        (s_we || s_rd) |-> (m_gnt == (NM'(1) << own)));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter with two masters.
module tb_mem_bus_arbiter;
    import bus_pkg::*;

    localparam int unsigned NM = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [NM-1:0]    m_req;
    logic [NM-1:0]    m_gnt;
    logic [NM*AW-1:0] m_a;
    logic [NM*DW-1:0] m_d;
    logic [NM-1:0]    m_we;
    logic [NM-1:0]    m_rd;
    logic [DW-1:0]    m_spo;
    logic [NM-1:0]    m_ready;
    logic [AW-1:0]    s_a;
    logic [DW-1:0]    s_d;
    logic             s_we;
    logic             s_rd;
    logic [DW-1:0]    s_spo;
    logic             s_ready;

    int vectors = 0;
    int miscompares = 0;
    logic saw_wr_200 = 1'b0;

    mem_bus_arbiter #(.NM(NM), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_gnt(m_gnt),
        .m_a(m_a), .m_d(m_d), .m_we(m_we), .m_rd(m_rd),
        .m_spo(m_spo), .m_ready(m_ready), .s_a(s_a), .s_d(s_d),
        .s_we(s_we), .s_rd(s_rd), .s_spo(s_spo), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    // Slave model: remember any write that reaches address 0x200
    always @(posedge clk) begin
        if (s_we && s_a == 32'h0000_0200) saw_wr_200 <= 1'b1;
    end

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic we, input logic rd);
        m_a[i*AW +: AW] = a;
        m_d[i*DW +: DW] = d;
        m_we[i] = we;
        m_rd[i] = rd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_req = '0; m_a = '0; m_d = '0; m_we = '0; m_rd = '0;
        s_spo = '0; s_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if (m_gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt got %b want 00", m_gnt); end
        vectors++;
        if ({s_we, s_rd, m_ready} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_strobes got %b want 0000", {s_we, s_rd, m_ready});
        end
        vectors++;
        if (s_a !== 32'h0 || s_d !== 32'h0) begin
            miscompares++; $display("FAIL reset_bus got a=%h d=%h want 0/0", s_a, s_d);
        end
    endtask

    task automatic test_single_write();
        repeat (4) tick();
        m_req = 2'b01;
        tick();
        vectors++;
        if (m_gnt !== 2'b01) begin miscompares++; $display("FAIL grant_m0 got %b want 01", m_gnt); end
        set_master(0, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0);
        #1;
        vectors++;
        if (s_a !== 32'h100 || s_d !== 32'hDEAD_BEEF || s_we !== 1'b1) begin
            miscompares++; $display("FAIL write_fwd got a=%h d=%h we=%b want 100/deadbeef/1", s_a, s_d, s_we);
        end
        vectors++;
        if (m_ready !== 2'b01) begin miscompares++; $display("FAIL write_ready got %b want 01", m_ready); end
        tick();
        set_master(0, '0, '0, 1'b0, 1'b0);
        m_req = 2'b00;
        tick();
        vectors++;
        if (m_gnt !== 2'b00) begin miscompares++; $display("FAIL release_idle got %b want 00", m_gnt); end
    endtask

    task automatic test_round_robin();
        do_reset();
        m_req = 2'b11;
        tick();
        vectors++;
        if (m_gnt !== 2'b01) begin miscompares++; $display("FAIL rr_tie got %b want 01", m_gnt); end
        m_req = 2'b10;
        tick();
        vectors++;
        if (m_gnt !== 2'b10) begin miscompares++; $display("FAIL rr_handoff got %b want 10", m_gnt); end
        m_req = 2'b01;
        tick();
        vectors++;
        if (m_gnt !== 2'b01) begin miscompares++; $display("FAIL rr_back got %b want 01", m_gnt); end
        m_req = 2'b00;
        tick();
        vectors++;
        if (m_gnt !== 2'b00) begin miscompares++; $display("FAIL rr_idle got %b want 00", m_gnt); end
    endtask

    task automatic test_hold_not_ready();
        int held_bad = 0;
        m_req = 2'b10;
        tick();
        vectors++;
        if (m_gnt !== 2'b10) begin miscompares++; $display("FAIL sb_grant got %b want 10", m_gnt); end
        m_req = 2'b11;
        set_master(MST_SERIALBOOT, 32'h300, 32'hA5A5_0001, 1'b1, 1'b0);
        s_ready = 1'b0;
        tick();
        set_master(MST_SERIALBOOT, 32'h300, 32'hA5A5_0001, 1'b0, 1'b0);
        m_req = 2'b01;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (m_gnt !== 2'b10) held_bad++;
        end
        vectors++;
        if (held_bad != 0) begin miscompares++; $display("FAIL sb_hold got %0d bad cycles want 0", held_bad); end
        s_ready = 1'b1;
        tick();
        vectors++;
        if (m_gnt !== 2'b01) begin miscompares++; $display("FAIL sb_handoff got %b want 01", m_gnt); end
        m_req = 2'b00;
        tick();
    endtask

    task automatic test_nonowner_strobe();
        m_req = 2'b01;
        tick();
        set_master(0, 32'h400, 32'h0, 1'b0, 1'b0);
        set_master(1, 32'h200, 32'h1111_2222, 1'b1, 1'b0);
        #1;
        vectors++;
        if (s_we !== 1'b0 || s_a !== 32'h400) begin
            miscompares++; $display("FAIL nonowner_we got we=%b a=%h want 0/400", s_we, s_a);
        end
        tick();
        set_master(1, '0, '0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (saw_wr_200 !== 1'b0) begin miscompares++; $display("FAIL nonowner_slave got %b want 0", saw_wr_200); end
    endtask

    task automatic test_read();
        set_master(0, 32'h40, 32'h0, 1'b0, 1'b1);
        s_spo = 32'h1234_5678;
        s_ready = 1'b1;
        #1;
        vectors++;
        if (m_ready !== 2'b01 || s_rd !== 1'b1) begin
            miscompares++; $display("FAIL read_ready got rdy=%b rd=%b want 01/1", m_ready, s_rd);
        end
        vectors++;
        if (m_spo !== 32'h1234_5678) begin miscompares++; $display("FAIL read_data got %h want 12345678", m_spo); end
        tick();
        set_master(0, '0, '0, 1'b0, 1'b0);
        m_req = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        m_req = 2'b10;
        tick();
        vectors++;
        if (m_gnt !== 2'b10) begin miscompares++; $display("FAIL mid_grant got %b want 10", m_gnt); end
        set_master(1, 32'h500, 32'hCAFE_F00D, 1'b1, 1'b0);
        s_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (m_gnt !== 2'b00 || s_we !== 1'b0 || s_rd !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset got gnt=%b we=%b rd=%b want 00/0/0", m_gnt, s_we, s_rd);
        end
        rst = 1'b0;
        set_master(1, '0, '0, 1'b0, 1'b0);
        s_ready = 1'b1;
        m_req = 2'b11;
        tick();
        vectors++;
        if (m_gnt !== 2'b01) begin miscompares++; $display("FAIL post_reset_prio got %b want 01", m_gnt); end
        m_req = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_hold_not_ready();
        test_nonowner_strobe();
        test_read();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
